bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side master for the simple dual-port coefficient BRAM (port B: enb/addrb/doutb).
//  On a start command it issues len sequential reads from base_addr and emits the words
//  as a valid/ready stream toward the NTT butterfly datapath.
//  Fixed BRAM read latency is absorbed, and stream back-pressure is handled by an
//  internal credit-controlled FIFO.
// PARAMETERS
//  DW          24  data width, equal to BRAM word width
//  AW          7   BRAM address width (depth 2**AW)
//  RD_LAT      1   BRAM read latency in cycles (enb/addrb edge -> doutb valid); legal 1..2
//  FIFO_DEPTH  4   output FIFO entries; must be >= RD_LAT+2, power of two
// PORTS
//  clk         in   1     single clock for all logic and the BRAM
//  rst         in   1     synchronous, active-high reset
//  start       in   1     command strobe; sampled only while state==IDLE
//  base_addr   in   AW    first read address, latched on an accepted start
//  len         in   AW+1  word count 0..2**AW, latched on an accepted start
//  busy        out  1     high whenever state != IDLE
//  done        out  1     one-cycle pulse when the command completes
//  enb         out  1     BRAM port-B read enable
//  addrb       out  AW    BRAM port-B read address
//  doutb       in   DW    BRAM port-B read data
//  m_valid     out  1     stream data valid
//  m_ready     in   1     stream sink ready
//  m_data      out  DW    stream data
//  m_last      out  1     high with the final beat of the command
// BEHAVIOUR
//  Reset values: busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0, m_last=0.
//   rst also clears the FSM, counters, FIFO and the in-flight valid pipeline.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE: start=1 and len!=0 -> latch base_addr/len, go to RUN.
//   IDLE: start=1 and len==0 -> done pulse in the next cycle, stay IDLE, enb never asserted.
//   start while busy is ignored; it is not queued.
//   RUN: enb=1 in a cycle iff issued<len and (inflight+fifo_count) < FIFO_DEPTH (credit).
//    With enb=1: addrb=cur_addr, and cur_addr increments modulo 2**AW.
//    Example: base 126, len 4 -> addresses 126,127,0,1.
//   RUN -> DRAIN on the cycle the len-th read is issued.
//   DRAIN: no reads. When the last beat handshakes (m_valid & m_ready & m_last):
//    done=1 on the next cycle, state returns to IDLE.
//  Read return: a 1-bit valid shift register of depth RD_LAT tracks each enb.
//   doutb is written to the FIFO exactly RD_LAT cycles after its enb.
//   Credit counts these in-flight reads, so the FIFO can never overflow.
//   A write arriving with the FIFO full is a design error (assertion).
//  Stream output: registered FIFO head.
//   m_valid=1 whenever the FIFO is non-empty; m_data/m_last are stable while m_valid & !m_ready.
//   Simultaneous push and pop is allowed and keeps the count unchanged.
//  m_last is a tag bit stored with the word; it is set for the read whose issue count equals len.
//  Latency: with m_ready held 1, the first m_valid occurs RD_LAT+2 cycles after the start
//   sample cycle.
//  Throughput: with m_ready held 1, one beat per cycle sustained. Total command time is
//   len+RD_LAT+2 cycles to the last beat; done follows one cycle later.
//  Back-pressure: m_ready=0 stalls issuing once credits are exhausted. No data is lost or
//   duplicated, and order is preserved.
//  Reset mid-operation: all state is cleared on the next edge. BRAM data returning after
//   rst is discarded. m_valid is 0 in the cycle after rst.
//  done and start in the same cycle: done is asserted in IDLE, so that start is accepted.
// TESTING
//  T1: BRAM preloaded mem[i]=i*3; base=0, len=8, m_ready=1.
//   -> m_data 0,3,..,21 on consecutive cycles; first m_valid at start+RD_LAT+2;
//   m_last on 21; done one cycle after.
//  T2: base=126, len=4.
//   -> addrb sequence 126,127,0,1; data mem[126],mem[127],mem[0],mem[1].
//  T3: len=16, m_ready random (50%).
//   -> all 16 words in order, no duplicates; enb never high while credit is 0;
//   FIFO never overflows.
//  T4: len=0.
//   -> done pulses the cycle after start; enb, m_valid and busy stay 0.
//  T5: rst asserted 3 cycles into a len=32 read.
//   -> next cycle busy=0 and m_valid=0; late BRAM returns are not emitted;
//   a new start (base=5, len=2) streams mem[5],mem[6].
//  T6: start pulsed while busy, and start on the done cycle.
//   -> the busy start is ignored; the done-cycle start launches the next command.
//   Repeat with RD_LAT=2 and FIFO_DEPTH=4.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Read-side master for the coefficient BRAM. It turns a start command into len
// sequential port-B reads and presents the returned words as a valid/ready stream.
// The BRAM latency is covered by a valid/last pipeline. A small FIFO absorbs sink
// stalls, and a credit check keeps the number of outstanding words within its depth.
module bram_stream_reader #(
  parameter int DW         = 24,
  parameter int AW         = 7,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  localparam logic [PW-1:0] PTR_ONE    = 1;
  localparam logic [AW-1:0] ADDR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [CW-1:0] FCNT_ONE   = 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] DEPTH_CRED = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]   cur_addr;
  logic [AW:0]     len_q;
  logic [AW:0]     issued;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] lpipe;
  logic [DW:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [SW-1:0]   inflight;
  logic [SW-1:0]   credit_used;
  logic [DW:0]     head;
  logic            credit_ok;
  logic            accept;
  logic            zero_cmd;
  logic            issue_last;
  logic            push;
  logic            pop;
  logic            last_pop;
  logic            done_q;

  assign accept      = (state == IDLE) && start && (len != '0);
  assign zero_cmd    = (state == IDLE) && start && (len == '0);
  assign credit_used = inflight + {1'b0, fifo_count};
  assign credit_ok   = credit_used < DEPTH_CRED;
  assign issue_last  = enb && ((issued + CNT_ONE) == len_q);
  assign push        = vpipe[RD_LAT-1];
  assign head        = fifo_mem[rd_ptr];
  assign m_valid     = (fifo_count != '0);
  assign m_data      = m_valid ? head[DW-1:0] : '0;
  assign m_last      = m_valid & head[DW];
  assign pop         = m_valid && m_ready;
  assign last_pop    = pop && head[DW];
  assign done        = done_q;

  // Count reads that have been issued but whose data has not yet reached the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + SW'(vpipe[i]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: run until the final read issues, then wait for the final beat to leave
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (issue_last) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a read issues only while words remain and the FIFO has room for it
  always_comb begin
    busy  = (state != IDLE);
    enb   = (state == RUN) && (issued < len_q) && credit_ok;
    addrb = enb ? cur_addr : '0;
  end

  // Command registers: latch on accept, advance the address and issue count per read
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      len_q    <= '0;
      issued   <= '0;
    end else if (accept) begin
      cur_addr <= base_addr;
      len_q    <= len;
      issued   <= '0;
    end else if (enb) begin
      cur_addr <= cur_addr + ADDR_ONE;
      issued   <= issued + CNT_ONE;
    end
  end

  // Done pulse one cycle after a zero-length command or after the last beat leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= zero_cmd || ((state == DRAIN) && last_pop);
    end
  end

  // Valid and last-tag pipeline matching the BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= enb;
      lpipe[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  // FIFO storage holds the word with its last tag; it needs no reset because count gates it
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {lpipe[RD_LAT-1], doutb};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_ONE;
        2'b01:   fifo_count <= fifo_count - FCNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A returning word must always find room; the credit check is meant to guarantee it
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == DEPTH_CNT)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader. Two copies run side by side, one with a single-cycle
// BRAM and one with a two-cycle BRAM, fed from the same coefficient image mem[i]=i*3.
// A negedge monitor records addresses, beats, done pulses and credit/stall behaviour.
module tb_bram_stream_reader;

  localparam int DW = 24;
  localparam int AW = 7;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       len;
  logic              m_ready;
  logic [1:0]        busy, done, enb, m_valid, m_last;
  logic [1:0][AW-1:0] addrb;
  logic [1:0][DW-1:0] doutb, m_data;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] stage2;

  int tests, failed, cyc, sCyc;
  logic clr;

  int nbeat [2];
  int nenb  [2];
  int ndone [2];
  int nbusy [2];
  int firstv[2];
  int viol  [2];
  int sviol [2];
  logic          prevStall[2];
  logic [DW-1:0] prevData [2];
  logic          prevLast [2];
  logic [DW-1:0] dat  [2][64];
  logic          lst  [2][64];
  int            bcyc [2][64];
  logic [AW-1:0] adr  [2][64];
  int            dcy  [2][4];

  bram_stream_reader #(.DW(DW), .AW(AW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr), .len(len),
    .busy(busy[0]), .done(done[0]), .enb(enb[0]), .addrb(addrb[0]), .doutb(doutb[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]), .m_last(m_last[0])
  );

  bram_stream_reader #(.DW(DW), .AW(AW), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr), .len(len),
    .busy(busy[1]), .done(done[1]), .enb(enb[1]), .addrb(addrb[1]), .doutb(doutb[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]), .m_last(m_last[1])
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time every observation
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: one-cycle read for dut1, two-cycle pipelined read for dut2
  always @(posedge clk) begin
    if (enb[0]) doutb[0] <= mem[addrb[0]];
    if (enb[1]) stage2 <= mem[addrb[1]];
    doutb[1] <= stage2;
  end

  // Monitor: records what each copy does, away from the active clock edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        nbeat[k] <= 0; nenb[k] <= 0; ndone[k] <= 0; nbusy[k] <= 0;
        firstv[k] <= -1; viol[k] <= 0; sviol[k] <= 0; prevStall[k] <= 1'b0;
      end else begin
        if (enb[k]) begin
          if ((nenb[k] - nbeat[k]) >= DEPTH) viol[k] <= viol[k] + 1;
          if (nenb[k] < 64) adr[k][nenb[k]] <= addrb[k];
          nenb[k] <= nenb[k] + 1;
        end
        if (m_valid[k] && firstv[k] < 0) firstv[k] <= cyc;
        if (prevStall[k] && (!m_valid[k] || m_data[k] != prevData[k] || m_last[k] != prevLast[k]))
          sviol[k] <= sviol[k] + 1;
        prevStall[k] <= m_valid[k] && !m_ready;
        prevData[k]  <= m_data[k];
        prevLast[k]  <= m_last[k];
        if (m_valid[k] && m_ready) begin
          if (nbeat[k] < 64) begin
            dat[k][nbeat[k]]  <= m_data[k];
            lst[k][nbeat[k]]  <= m_last[k];
            bcyc[k][nbeat[k]] <= cyc;
          end
          nbeat[k] <= nbeat[k] + 1;
        end
        if (done[k]) begin
          if (ndone[k] < 4) dcy[k][ndone[k]] <= cyc;
          ndone[k] <= ndone[k] + 1;
        end
        if (busy[k]) nbusy[k] <= nbusy[k] + 1;
      end
    end
  end

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Clear the monitor records, then pulse start on both copies for one cycle
  task automatic applyStimulus(input int b, input int l);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    start = 2'b11;
    sCyc = cyc;
    @(posedge clk); #1;
    start = 2'b00;
  endtask

  // Run until both copies have pulsed done nd times, with optional random ready
  // and optional relaunch of a command exactly on each copy's first done cycle
  task automatic waitDone(input int nd, input bit rnd, input bit chain);
    logic [1:0] launched;
    int n;
    launched = 2'b00;
    n = 0;
    while (!(ndone[0] >= nd && ndone[1] >= nd) && n < 500) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (chain) begin
        for (int k = 0; k < 2; k++) begin
          if (!launched[k] && done[k]) begin
            start[k] = 1'b1;
            launched[k] = 1'b1;
          end else begin
            start[k] = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
      n++;
    end
    start = 2'b00;
    m_ready = 1'b1;
  endtask

  // Compare a recorded command against the expected addresses, words and timing
  task automatic checkStream(input string tag, input int b, input int l, input bit timing);
    int a;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_k%0d_beats", tag, k), nbeat[k], l);
      checkOutput($sformatf("%s_k%0d_reads", tag, k), nenb[k], l);
      for (int i = 0; i < l && i < 64; i++) begin
        a = (b + i) % 128;
        checkOutput($sformatf("%s_k%0d_addr%0d", tag, k, i), adr[k][i], a);
        checkOutput($sformatf("%s_k%0d_data%0d", tag, k, i), dat[k][i], a * 3);
        checkOutput($sformatf("%s_k%0d_last%0d", tag, k, i), lst[k][i], (i == l - 1));
      end
      if (timing) begin
        checkOutput($sformatf("%s_k%0d_firstv", tag, k), firstv[k], sCyc + k + 3);
        checkOutput($sformatf("%s_k%0d_lastcyc", tag, k), bcyc[k][l-1], sCyc + k + 3 + l - 1);
      end
      checkOutput($sformatf("%s_k%0d_ndone", tag, k), ndone[k], 1);
      checkOutput($sformatf("%s_k%0d_donecyc", tag, k), dcy[k][0], bcyc[k][l-1] + 1);
      checkOutput($sformatf("%s_k%0d_credit", tag, k), viol[k], 0);
      checkOutput($sformatf("%s_k%0d_stall", tag, k), sviol[k], 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = DW'(i * 3);
    rst = 1'b1; start = 2'b00; base_addr = '0; len = '0; m_ready = 1'b1;
    clr = 1'b1; tests = 0; failed = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_k%0d_busy", k), busy[k], 0);
      checkOutput($sformatf("rst_k%0d_done", k), done[k], 0);
      checkOutput($sformatf("rst_k%0d_enb", k), enb[k], 0);
      checkOutput($sformatf("rst_k%0d_addrb", k), addrb[k], 0);
      checkOutput($sformatf("rst_k%0d_mvalid", k), m_valid[k], 0);
      checkOutput($sformatf("rst_k%0d_mdata", k), m_data[k], 0);
      checkOutput($sformatf("rst_k%0d_mlast", k), m_last[k], 0);
    end
    rst = 1'b0;

    // T1: basic streaming with the sink always ready
    applyStimulus(0, 8);
    waitDone(1, 1'b0, 1'b0);
    checkStream("T1", 0, 8, 1'b1);

    // T2: address wrap at the top of the BRAM
    applyStimulus(126, 4);
    waitDone(1, 1'b0, 1'b0);
    checkStream("T2", 126, 4, 1'b1);

    // T3: random back-pressure
    applyStimulus(40, 16);
    waitDone(1, 1'b1, 1'b0);
    checkStream("T3", 40, 16, 1'b0);

    // T4: zero-length command
    applyStimulus(7, 0);
    waitDone(1, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("T4_k%0d_ndone", k), ndone[k], 1);
      checkOutput($sformatf("T4_k%0d_donecyc", k), dcy[k][0], sCyc + 1);
      checkOutput($sformatf("T4_k%0d_reads", k), nenb[k], 0);
      checkOutput($sformatf("T4_k%0d_beats", k), nbeat[k], 0);
      checkOutput($sformatf("T4_k%0d_busy", k), nbusy[k], 0);
      checkOutput($sformatf("T4_k%0d_firstv", k), firstv[k], -1);
    end

    // T5: reset in the middle of a long command, then a fresh command
    applyStimulus(0, 32);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("T5_k%0d_busy_after_rst", k), busy[k], 0);
      checkOutput($sformatf("T5_k%0d_mvalid_after_rst", k), m_valid[k], 0);
    end
    repeat (6) begin @(posedge clk); #1; end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("T5_k%0d_late_beats", k), nbeat[k], 0);
      checkOutput($sformatf("T5_k%0d_late_reads", k), nenb[k], 0);
    end
    applyStimulus(5, 2);
    waitDone(1, 1'b0, 1'b0);
    checkStream("T5", 5, 2, 1'b1);

    // T6: a start while busy is dropped; a start on the done cycle is taken
    applyStimulus(10, 3);
    start = 2'b11; base_addr = 7'd50; len = 8'd5;
    @(posedge clk); #1;
    start = 2'b00; base_addr = 7'd20; len = 8'd4;
    waitDone(2, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("T6_k%0d_beats", k), nbeat[k], 7);
      checkOutput($sformatf("T6_k%0d_reads", k), nenb[k], 7);
      checkOutput($sformatf("T6_k%0d_ndone", k), ndone[k], 2);
      for (int i = 0; i < 7; i++) begin
        checkOutput($sformatf("T6_k%0d_data%0d", k, i), dat[k][i], (i < 3) ? (10 + i) * 3 : (17 + i) * 3);
        checkOutput($sformatf("T6_k%0d_last%0d", k, i), lst[k][i], (i == 2 || i == 6));
      end
      checkOutput($sformatf("T6_k%0d_done1cyc", k), dcy[k][0], bcyc[k][2] + 1);
      checkOutput($sformatf("T6_k%0d_second_first", k), bcyc[k][3], dcy[k][0] + k + 3);
      checkOutput($sformatf("T6_k%0d_done2cyc", k), dcy[k][1], bcyc[k][6] + 1);
      checkOutput($sformatf("T6_k%0d_credit", k), viol[k], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
